// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//   Two-requester arbiter in front of a single APB master port. One transfer
//   is in flight at a time. Ties alternate between the requesters. An ACCESS
//   phase that never sees pready is aborted after TIMEOUT cycles.
//
// Handshake: a requester raises req[i] with its fields valid and holds all of
//   them until done[i] pulses. done[i] is a single-cycle pulse and is the only
//   acknowledge. rdata/err are meaningful only while done != 0. The requester
//   drops req[i] on the edge that samples done[i]=1. If req[i] is still high in
//   IDLE, it starts a new transfer.
//
// Ports
//   pclk, presetn         clock, asynchronous active-low reset
//   req[1:0]              per-requester transfer request
//   addr, wdata           packed per-requester slices (slice i = requester i)
//   write[1:0], strb[7:0] per-requester direction and byte strobes (4 bits each)
//   rdata, done, err      completion data, one-cycle done pulse, error flag
//   busy                  high whenever the FSM is not in IDLE
//   paddr..pstb           APB request fields (registered at grant)
//   psel, penable         APB phase controls
//   prdata, pready, perr  APB slave response
//   fsm_state             current FSM state (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
// ---------------------------------------------------------------------------
module apb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [1:0]                req,
  input  logic [2*ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wdata,
  input  logic [1:0]                write,
  input  logic [7:0]                strb,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                done,
  output logic                      err,
  output logic                      busy,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic                      pwrite,
  output logic [3:0]                pstb,
  output logic                      psel,
  output logic                      penable,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      perr,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The counter value on the last permitted ACCESS cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_next;
  logic                  grant;       // index of the requester in flight
  logic                  last_grant;  // index of the most recent grant
  logic                  grant_sel;   // winner of the current arbitration
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  start;
  logic                  access_ok;
  logic                  access_to;
  logic                  access_wait;

  // Next-state logic, including the qualifiers the datapath uses.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    access_ok   = 1'b0;
    access_to   = 1'b0;
    access_wait = 1'b0;
    // A lone requester wins. On a tie, the requester not granted last wins.
    grant_sel   = (req == 2'b11) ? ~last_grant : req[1];
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          start      = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        // pready takes priority over the timeout on the final permitted cycle.
        if (pready) begin
          access_ok  = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          access_to  = 1'b1;
          state_next = RESP;
        end else begin
          access_wait = 1'b1;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_next;
  end

  // Grant bookkeeping, request-field capture, timeout counter and response capture.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 8'd0;
      paddr      <= '0;
      pwdata     <= '0;
      pwrite     <= 1'b0;
      pstb       <= 4'b0000;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start) begin
        grant      <= grant_sel;
        last_grant <= grant_sel;
        cnt        <= 8'd0;
        paddr      <= grant_sel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        pwdata     <= grant_sel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
        pwrite     <= write[grant_sel];
        // Reads never carry byte strobes.
        pstb       <= write[grant_sel] ? (grant_sel ? strb[7:4] : strb[3:0]) : 4'b0000;
      end
      if (access_wait) cnt <= cnt + 8'd1;
      if (access_ok) begin
        rdata_q <= prdata;
        err_q   <= perr;
      end
      if (access_to) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Outputs decode from the state, so reset clears them immediately.
  always_comb begin
    psel      = (state == SETUP) || (state == ACCESS);
    penable   = (state == ACCESS);
    busy      = (state != IDLE);
    done      = 2'b00;
    rdata     = '0;
    err       = 1'b0;
    fsm_state = state;
    if (state == RESP) begin
      done  = grant ? 2'b10 : 2'b01;
      rdata = rdata_q;
      err   = err_q;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
//   Directed bench for apb_arbiter with TIMEOUT=4. Expected completions
//   {done, rdata, err} are pushed when a request is driven. They are popped and
//   compared when done pulses. Grant order comes from a small last-grant model.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;
  localparam int TO = 4;
  localparam int W  = 35;   // {done[1:0], rdata[31:0], err}

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  write = '0;
  logic [7:0]  strb = '0;
  logic [31:0] rdata;
  logic [1:0]  done;
  logic        err;
  logic        busy;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        perr = 1'b0;
  logic [1:0]  fsm_state;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         tb_last = 1'b1;

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .addr(addr), .wdata(wdata),
    .write(write), .strb(strb), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pstb(pstb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
    .perr(perr), .fsm_state(fsm_state)
  );

  // clock
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request from IDLE and acts as the APB slave. pready rises on
  // ACCESS cycle wait_n+1. hold keeps req high after done.
  task automatic xfer(input logic [1:0] rq, input int wait_n, input logic [31:0] rd,
                      input logic pe, input logic hold);
    logic        g, ewr, to;
    logic [1:0]  ed;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    logic [63:0] sv_addr, sv_wdata;
    logic [1:0]  sv_write;
    logic [7:0]  sv_strb;
    logic [W-1:0] want;
    int acc, lat, exp_acc;
    @(negedge pclk);
    chk("idle_before", {busy, fsm_state}, 3'b000);
    g       = (rq == 2'b11) ? ~tb_last : rq[1];
    tb_last = g;
    ed      = g ? 2'b10 : 2'b01;
    ea      = g ? addr[63:32] : addr[31:0];
    ew      = g ? wdata[63:32] : wdata[31:0];
    ewr     = write[g];
    es      = ewr ? (g ? strb[7:4] : strb[3:0]) : 4'b0000;
    to      = (wait_n >= TO);
    exp_acc = to ? TO : wait_n + 1;
    exp_q.push_back({ed, to ? 32'h0 : rd, to ? 1'b1 : pe});
    req = rq;
    sv_addr = addr; sv_wdata = wdata; sv_write = write; sv_strb = strb;
    acc = 0; lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge pclk);
      if (k == 1)
        chk("setup", {fsm_state, psel, penable, busy, paddr, pwdata, pwrite, pstb},
            {2'd1, 1'b1, 1'b0, 1'b1, ea, ew, ewr, es});
      if (psel && penable) begin
        acc++;
        chk("access_fields", {paddr, pwdata, pwrite, pstb}, {ea, ew, ewr, es});
        // Request-field changes mid-flight must not reach the APB side.
        if (acc == 1) begin
          addr  = {$urandom, $urandom};
          wdata = {$urandom, $urandom};
          write = 2'($urandom_range(0, 3));
          strb  = 8'($urandom_range(0, 255));
        end
        pready = (acc == wait_n + 1);
        prdata = rd;
        perr   = pe;
      end else begin
        pready = 1'b0;
      end
      if (done != 2'b00) lat = k;
      else chk("no_resp_outside_resp", {done, rdata, err}, 35'h0);
    end
    chk("done_seen", 1'(lat != 0), 1'b1);
    want = exp_q.pop_front();
    if (lat != 0) begin
      chk("resp", {done, rdata, err}, want);
      chk("resp_phase_and_hold", {psel, penable, paddr, pwdata, pwrite, pstb},
          {1'b0, 1'b0, ea, ew, ewr, es});
      chk("latency", 32'(lat), 32'(2 + exp_acc));
      chk("access_cycles", 32'(acc), 32'(exp_acc));
    end
    addr = sv_addr; wdata = sv_wdata; write = sv_write; strb = sv_strb;
    if (!hold) req = 2'b00;
  endtask

  initial begin
    // Reset: outputs forced to zero asynchronously.
    #2 presetn = 1'b0;
    #1 chk("reset_async", {psel, penable, done, err, busy, rdata, paddr, pwdata, pwrite, pstb, fsm_state}, 0);
    @(negedge pclk);
    @(negedge pclk);
    chk("reset_held", {psel, penable, done, err, busy, rdata, paddr, pwdata, pwrite, pstb, fsm_state}, 0);
    presetn = 1'b1;
    tb_last = 1'b1;

    // Write by requester 0, ready on the first ACCESS cycle.
    addr[31:0] = 32'h10; wdata[31:0] = 32'h41; strb[3:0] = 4'hF; write[0] = 1'b1;
    xfer(2'b01, 0, 32'h0, 1'b0, 1'b0);

    // Read by requester 1 after 3 wait cycles. Strobes must be suppressed.
    addr[63:32] = 32'h2000; wdata[63:32] = 32'h99; strb[7:4] = 4'hA; write[1] = 1'b0;
    xfer(2'b10, 3, 32'hDEADBEEF, 1'b0, 1'b0);

    // Slave error with pready.
    write[0] = 1'b0; addr[31:0] = 32'h44;
    xfer(2'b01, 0, 32'h0000CAFE, 1'b1, 1'b0);

    // Timeout: pready never rises.
    xfer(2'b10, 99, 32'h5555, 1'b0, 1'b0);

    // pready on the final permitted cycle beats the timeout.
    xfer(2'b01, TO - 1, 32'hA5A5A5A5, 1'b1, 1'b0);
    xfer(2'b10, TO - 1, 32'h11112222, 1'b0, 1'b0);

    // Tie with req=11 held throughout: grants alternate.
    write = 2'b11; strb = 8'h5C;
    addr = {32'hB000_0004, 32'hA000_0008}; wdata = {32'h1111_0001, 32'h2222_0002};
    xfer(2'b11, 0, 32'h1, 1'b0, 1'b1);
    xfer(2'b11, 1, 32'h2, 1'b0, 1'b1);
    xfer(2'b11, 2, 32'h3, 1'b1, 1'b1);
    xfer(2'b11, 0, 32'h4, 1'b0, 1'b0);

    // Reset during ACCESS: immediate zero outputs, no done, fresh arbitration.
    @(negedge pclk);
    req = 2'b11;
    @(negedge pclk);
    @(negedge pclk);
    pready = 1'b0;
    chk("abort_in_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1 chk("abort_outputs", {psel, penable, done, err, busy, rdata, paddr, pwdata, pwrite, pstb, fsm_state}, 0);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("abort_no_done", done, 2'b00);
    end
    presetn = 1'b1;
    tb_last = 1'b1;
    xfer(2'b11, 1, 32'h77, 1'b0, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
